hd44780_textbuf: RTL

Character text buffer and refresh scheduler that sits directly upstream of the HD44780 4-bit LCD driver. It accepts a byte stream from a host, interprets printable characters and a small set of control codes into a 64-entry screen image (4 lines × 16 columns), and serves that image to the driver's character read port. It pulses the driver's trigger whenever the image has changed and the driver is idle.

---
 rtl/hd44780_pkg.sv | 16 +
 rtl/hd44780_charram.sv | 21 ++
 rtl/hd44780_textbuf.sv | 96 +++++++++
 3 files changed

// File: rtl/hd44780_pkg.sv
// hd44780_pkg: shared geometry, control codes and state types for the LCD text buffer
package hd44780_pkg;
  localparam int LINE_WIDTH = 16;
  localparam int NUM_LINES = 4;
  localparam int MAX_MEM = LINE_WIDTH * NUM_LINES;
  localparam int MAX_MEM_BITS = $clog2(MAX_MEM);
  localparam int EXPECTED_FREQ = 250_000;
  localparam logic [7:0] CC_LF = 8'h0A;
  localparam logic [7:0] CC_FF = 8'h0C;
  localparam logic [7:0] CC_CR = 8'h0D;
  typedef enum logic {WR_CLEAR, WR_RUN} wr_state_t;
  typedef enum logic [1:0] {TR_IDLE, TR_HOLD, TR_ARMED} trg_state_t;
  function automatic logic is_printable(input logic [7:0] c);
    return c >= 8'h20 && c <= 8'h7E;
  endfunction
endpackage

// File: rtl/hd44780_charram.sv
// hd44780_charram: 64x8 screen image, sync write, registered read-before-write read port
module hd44780_charram
  import hd44780_pkg::*;
#(
  parameter logic [7:0] FILL_CHAR = 8'h20
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [MAX_MEM_BITS-1:0] waddr,
  input  logic [7:0]              wdata,
  input  logic [MAX_MEM_BITS-1:0] raddr,
  output logic [7:0]              rdata
);
  logic [7:0] mem [MAX_MEM];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  always_ff @(posedge clk or negedge rst)
    if (!rst) rdata <= FILL_CHAR;
    else rdata <= mem[raddr];
endmodule

// File: rtl/hd44780_textbuf.sv
// hd44780_textbuf: host byte decoder, cursor, clear FSM and refresh scheduler for the HD44780 driver
module hd44780_textbuf
  import hd44780_pkg::*;
#(
  parameter logic [7:0] FILL_CHAR       = 8'h20,
  parameter int         REFRESH_HOLDOFF = 250
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    host_valid,
  output logic                    host_ready,
  input  logic [7:0]              host_data,
  input  logic [MAX_MEM_BITS-1:0] idataaddr,
  output logic [7:0]              idata,
  output logic                    trg,
  input  logic                    busy,
  output logic                    dirty
);
  localparam int CW = $clog2(REFRESH_HOLDOFF + 1) < 1 ? 1 : $clog2(REFRESH_HOLDOFF + 1);
  localparam logic [CW-1:0] HOLD_V = CW'(REFRESH_HOLDOFF);
  wr_state_t               wr_state;
  trg_state_t              tr_state;
  logic [MAX_MEM_BITS-1:0] cursor, clr_addr, waddr;
  logic [CW-1:0]           cnt;
  logic [7:0]              wdata;
  logic acc, prt, is_cr, is_lf, is_ff, clr_done, set_dirty, fire, we;
  always_comb begin
    acc       = host_valid && host_ready;
    prt       = acc && is_printable(host_data);
    is_cr     = acc && host_data == CC_CR;
    is_lf     = acc && host_data == CC_LF;
    is_ff     = acc && host_data == CC_FF;
    clr_done  = wr_state == WR_CLEAR && clr_addr == MAX_MEM_BITS'(MAX_MEM - 1);
    set_dirty = prt || is_cr || is_lf || is_ff || clr_done;
    fire      = tr_state == TR_IDLE && !busy && cnt == '0 && dirty && wr_state == WR_RUN;
    we        = wr_state == WR_CLEAR || prt;
    waddr     = wr_state == WR_CLEAR ? clr_addr : cursor;
    wdata     = wr_state == WR_CLEAR ? FILL_CHAR : host_data;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_state   <= WR_CLEAR;
      clr_addr   <= '0;
      cursor     <= '0;
      host_ready <= 1'b0;
    end else if (wr_state == WR_CLEAR) begin
      clr_addr <= clr_addr + 1'b1;
      if (clr_done) begin
        wr_state   <= WR_RUN;
        host_ready <= 1'b1;
      end
    end else begin
      cursor <= is_ff ? '0 :
                is_lf ? {cursor[5:4] + 2'd1, 4'h0} :
                is_cr ? {cursor[5:4], 4'h0} :
                prt   ? cursor + 1'b1 : cursor;
      if (is_ff) begin
        wr_state   <= WR_CLEAR;
        clr_addr   <= '0;
        host_ready <= 1'b0;
      end
    end
  // A write landing on the trigger edge keeps dirty set so a follow-up refresh repairs a torn frame
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      tr_state <= TR_IDLE;
      cnt      <= '0;
      trg      <= 1'b0;
      dirty    <= 1'b0;
    end else begin
      trg   <= fire;
      dirty <= set_dirty || (dirty && !fire);
      case (tr_state)
        TR_IDLE:  if (fire) tr_state <= TR_ARMED;
        TR_ARMED: if (busy) begin
          tr_state <= TR_HOLD;
          cnt      <= HOLD_V;
        end
        TR_HOLD:  if (busy) cnt <= HOLD_V;
        else begin
          cnt <= cnt == '0 ? '0 : cnt - 1'b1;
          if (cnt <= CW'(1)) tr_state <= TR_IDLE;
        end
        default:  tr_state <= TR_IDLE;
      endcase
    end
  hd44780_charram #(.FILL_CHAR(FILL_CHAR)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (idataaddr),
    .rdata (idata)
  );
endmodule
